hazard_control_unit: RTL and testbench

//  Producer of the STALL/DUMP controls consumed by the Fetch/Decode and Decode/Execute pipeline registers.

---
 rtl/riscv_pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_control_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding, register-index width
// and the instruction word used to fill flushed pipeline slots.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    LU_BUBBLE,
    FLUSH,
    MEM_WAIT
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts qualifying cycles, holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment on request until the all-ones value is reached, then hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: generates STALL/DUMP controls for the
// Fetch/Decode and Decode/Execute registers from load-use, taken-branch and
// data-memory-wait conditions, and keeps saturating stall/flush counters.
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_W   = riscv_pipe_pkg::REG_ADDR_W,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_Decode,
  input  logic [REG_ADDR_W-1:0] rs2_Decode,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd_Execute,
  input  logic                  mem_read_Execute,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  STALL_Fetch,
  output logic                  STALL_Decode,
  output logic                  DUMP_Fetch_Decode,
  output logic                  DUMP_Decode_Execute,
  output logic                  pc_write_en,
  output logic                  pc_redirect,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  import riscv_pipe_pkg::*;

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  hz_state_t         state, state_next;
  hz_state_t         saved, saved_next;
  logic [FCNT_W-1:0] fcnt, fcnt_next;
  logic              load_use;
  logic              branch_event;

  assign load_use = mem_read_Execute && (rd_Execute != '0) &&
                    ((use_rs1 && (rs1_Decode == rd_Execute)) ||
                     (use_rs2 && (rs2_Decode == rd_Execute)));

  // State, saved return state and remaining flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      saved <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      saved <= saved_next;
      fcnt  <= fcnt_next;
    end
  end

  // Next state and 0-latency controls; reset forces both pipeline registers to NOP.
  always_comb begin
    state_next          = state;
    saved_next          = saved;
    fcnt_next           = fcnt;
    STALL_Fetch         = 1'b0;
    STALL_Decode        = 1'b0;
    DUMP_Fetch_Decode   = 1'b0;
    DUMP_Decode_Execute = 1'b0;
    pc_redirect         = 1'b0;
    branch_event        = 1'b0;

    case (state)
      RUN: begin
        if (mem_busy) begin
          STALL_Fetch  = 1'b1;
          STALL_Decode = 1'b1;
          saved_next   = RUN;
          state_next   = MEM_WAIT;
        end else if (branch_taken) begin
          DUMP_Fetch_Decode   = 1'b1;
          DUMP_Decode_Execute = 1'b1;
          pc_redirect         = 1'b1;
          branch_event        = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            fcnt_next  = FCNT_LOAD;
            state_next = FLUSH;
          end
        end else if (load_use) begin
          STALL_Fetch         = 1'b1;
          DUMP_Decode_Execute = 1'b1;
          state_next          = LU_BUBBLE;
        end
      end

      LU_BUBBLE: begin
        if (mem_busy) begin
          STALL_Fetch  = 1'b1;
          STALL_Decode = 1'b1;
          saved_next   = LU_BUBBLE;
          state_next   = MEM_WAIT;
        end else begin
          state_next = RUN;
        end
      end

      FLUSH: begin
        if (mem_busy) begin
          STALL_Fetch  = 1'b1;
          STALL_Decode = 1'b1;
          saved_next   = FLUSH;
          state_next   = MEM_WAIT;
        end else begin
          DUMP_Fetch_Decode = 1'b1;
          fcnt_next         = fcnt - FCNT_W'(1);
          if (fcnt == FCNT_W'(1)) begin
            state_next = RUN;
          end
        end
      end

      MEM_WAIT: begin
        STALL_Fetch  = 1'b1;
        STALL_Decode = 1'b1;
        if (!mem_busy) begin
          state_next = saved;
        end
      end

      default: state_next = RUN;
    endcase

    if (reset) begin
      STALL_Fetch         = 1'b0;
      STALL_Decode        = 1'b0;
      DUMP_Fetch_Decode   = 1'b1;
      DUMP_Decode_Execute = 1'b1;
      pc_redirect         = 1'b0;
      branch_event        = 1'b0;
    end
  end

  assign pc_write_en = ~STALL_Fetch & ~reset;

  sat_counter #(.CNT_W(CNT_W)) u_stall_count (
    .clock (clock),
    .reset (reset),
    .inc   (STALL_Fetch),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_count (
    .clock (clock),
    .reset (reset),
    .inc   (branch_event),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a vector table for single-cycle
// behaviour plus hand sequences for memory-wait, counter saturation and reset.
module tb_hazard_control_unit;

  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic [4:0]    rs1_Decode, rs2_Decode, rd_Execute;
  logic          use_rs1, use_rs2, mem_read_Execute, branch_taken, mem_busy;
  logic          STALL_Fetch, STALL_Decode, DUMP_Fetch_Decode, DUMP_Decode_Execute;
  logic          pc_write_en, pc_redirect;
  logic [CW-1:0] stall_count, flush_count;

  int n_cmp;
  int n_fail;
  int exp_stall;
  int exp_flush;

  hazard_control_unit #(
    .REG_ADDR_W   (5),
    .FLUSH_CYCLES (2),
    .CNT_W        (CW)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .rs1_Decode          (rs1_Decode),
    .rs2_Decode          (rs2_Decode),
    .use_rs1             (use_rs1),
    .use_rs2             (use_rs2),
    .rd_Execute          (rd_Execute),
    .mem_read_Execute    (mem_read_Execute),
    .branch_taken        (branch_taken),
    .mem_busy            (mem_busy),
    .STALL_Fetch         (STALL_Fetch),
    .STALL_Decode        (STALL_Decode),
    .DUMP_Fetch_Decode   (DUMP_Fetch_Decode),
    .DUMP_Decode_Execute (DUMP_Decode_Execute),
    .pc_write_en         (pc_write_en),
    .pc_redirect         (pc_redirect),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // exp bits: {STALL_Fetch, STALL_Decode, DUMP_Fetch_Decode, DUMP_Decode_Execute, pc_redirect}
  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       busy;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs mid-cycle, check the combinational controls,
  // and advance the expected counters by what this cycle should contribute.
  task automatic step(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic busy,
                      input logic [4:0] exp);
    @(negedge clock);
    rs1_Decode       = rs1;
    rs2_Decode       = rs2;
    use_rs1          = u1;
    use_rs2          = u2;
    rd_Execute       = rd;
    mem_read_Execute = mr;
    branch_taken     = br;
    mem_busy         = busy;
    #1;
    check({nm, ".ctrl"},
          {27'd0, STALL_Fetch, STALL_Decode, DUMP_Fetch_Decode, DUMP_Decode_Execute, pc_redirect},
          {27'd0, exp});
    check({nm, ".pcwe"}, {31'd0, pc_write_en}, {31'd0, ~exp[4]});
    if (exp[4] && exp_stall < CMAX) exp_stall++;
    if (exp[0] && exp_flush < CMAX) exp_flush++;
  endtask

  task automatic idle(input string nm, input logic [4:0] exp);
    step(nm, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic check_counts(input string nm);
    @(negedge clock);
    #1;
    check({nm, ".stall_count"}, {28'd0, stall_count}, exp_stall);
    check({nm, ".flush_count"}, {28'd0, flush_count}, exp_flush);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_stall = 0; exp_flush = 0;

    tbl[0]  = '{"idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{"lu_rs1",      5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'b10010};
    tbl[2]  = '{"lu_bubble",   5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{"rd_x0",       5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[4]  = '{"lu_rs2",      5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'b10010};
    tbl[5]  = '{"after_lu",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[6]  = '{"not_load",    5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[7]  = '{"src_unused",  5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[8]  = '{"branch",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00111};
    tbl[9]  = '{"flush_ignbr", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00100};
    tbl[10] = '{"post_flush",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[11] = '{"br_beats_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'b00111};
    tbl[12] = '{"flush2",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00100};
    tbl[13] = '{"busy_run",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000};
    tbl[14] = '{"mw_no_hz",    5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 5'b11000};
    tbl[15] = '{"mw_release",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[16] = '{"back_run",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};

    reset = 1'b1;
    rs1_Decode = '0; rs2_Decode = '0; rd_Execute = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; mem_read_Execute = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
    #2;
    check("rst.ctrl",
          {27'd0, STALL_Fetch, STALL_Decode, DUMP_Fetch_Decode, DUMP_Decode_Execute, pc_redirect},
          32'b00110);
    check("rst.pcwe", {31'd0, pc_write_en}, 32'd0);
    check("rst.stall_count", {28'd0, stall_count}, 32'd0);
    check("rst.flush_count", {28'd0, flush_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int unsigned i = 0; i < 17; i++) begin
      step(tbl[i].name, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
           tbl[i].mr, tbl[i].br, tbl[i].busy, tbl[i].exp);
    end
    check_counts("table");

    // Memory wait entered from FLUSH with one flush cycle left.
    step("s5_branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00111);
    step("s5_busy0",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000);
    step("s5_busy1",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000);
    idle("s5_release", 5'b11000);
    idle("s5_flush",   5'b00100);
    idle("s5_run",     5'b00000);
    check_counts("s5");

    // Memory wait entered from LU_BUBBLE returns to the bubble, then RUN.
    step("lub_lu",   5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'b10010);
    step("lub_busy", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000);
    idle("lub_release", 5'b11000);
    step("lub_bubble", 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'b00000);
    idle("lub_run", 5'b00000);
    check_counts("lub");

    // Drive both counters past their maximum.
    for (int unsigned i = 0; i < 6; i++) begin
      step("sat_busy", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000);
    end
    idle("sat_release", 5'b11000);
    for (int unsigned i = 0; i < 14; i++) begin
      step("sat_branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00111);
      idle("sat_flush", 5'b00100);
    end
    check_counts("sat");
    check("sat.stall_max", {28'd0, stall_count}, CMAX);
    check("sat.flush_max", {28'd0, flush_count}, CMAX);

    // Reset asserted while in MEM_WAIT takes effect without a clock edge.
    step("r_busy", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("r_mid.ctrl",
          {27'd0, STALL_Fetch, STALL_Decode, DUMP_Fetch_Decode, DUMP_Decode_Execute, pc_redirect},
          32'b00110);
    check("r_mid.pcwe", {31'd0, pc_write_en}, 32'd0);
    check("r_mid.stall_count", {28'd0, stall_count}, 32'd0);
    check("r_mid.flush_count", {28'd0, flush_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mem_busy = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    idle("r_after", 5'b00000);
    step("r_lu", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'b10010);
    idle("r_bubble", 5'b00000);
    check_counts("r_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
